// File: rtl/bist_pkg.sv
// Shared definitions for the exhaustive-sweep engine: FSM encodings and
// commonly used MISR feedback polynomials.
`timescale 1ns/1ps
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0]  POLY8  = 8'h1D;
  localparam logic [15:0] POLY16 = 16'h1021;
  localparam logic [31:0] POLY32 = 32'h04C1_1DB7;

endpackage

// File: rtl/bist_sweep_if.sv
// Bundle between the sweep engine and its environment.
// Handshake: start and abort are single-cycle-sampled level inputs (no ready);
// vec is a valid stimulus whenever vec_valid is high, and resp must be the
// combinational response to vec in that same cycle. done/pass are levels held
// until the next start, abort or reset. state mirrors the FSM for observers.
`timescale 1ns/1ps
interface bist_sweep_if #(
  parameter int N     = 4,
  parameter int M     = 2,
  parameter int SIG_W = 16
) ();
  logic             start;
  logic             abort;
  logic [M-1:0]     resp;
  logic [N-1:0]     vec;
  logic             vec_valid;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [1:0]       state;

  modport master (
    input  start, abort, resp,
    output vec, vec_valid, busy, done, pass, signature, state
  );

  modport slave (
    output start, abort, resp,
    input  vec, vec_valid, busy, done, pass, signature, state
  );
endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback
// from the MSB and folds the zero-extended response into the low bits.
`timescale 1ns/1ps
module bist_misr #(
  parameter int               SIG_W = 16,
  parameter int               M     = 2,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [M-1:0]     din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] feedback;

  assign feedback = sig[SIG_W-1] ? POLY : '0;

  // Signature register: clear wins over absorb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ feedback ^ SIG_W'(din);
    end
  end

endmodule

// File: rtl/bist_sweep.sv
// Exhaustive-stimulus engine: walks all 2^N input vectors in ascending order,
// holds each for HOLD cycles, compacts responses into a MISR and compares the
// final signature against GOLDEN.
`timescale 1ns/1ps
module bist_sweep
  import bist_pkg::*;
#(
  parameter int               N      = 4,
  parameter int               M      = 2,
  parameter int               HOLD   = 1,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(POLY16),
  parameter logic [SIG_W-1:0] GOLDEN = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  bist_sweep_if.master bus
);

  // A 1-bit hold counter is kept even for HOLD=1 so the logic stays uniform.
  localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  state_t           state_q;
  state_t           state_d;
  logic             launch;
  logic [HW-1:0]    hold_q;
  // One extra bit so the step past vector 2^N-1 lands on 2^N, not 0.
  logic [N:0]       cnt_q;
  logic [N:0]       cnt_inc;
  logic             step;
  logic             last_step;
  logic             pass_q;
  logic [SIG_W-1:0] sig;
  logic             misr_clr;
  logic             misr_en;

  // Signature value the MISR will hold after absorbing the current response;
  // used so the golden compare can be registered on the final capture edge.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                 input logic [M-1:0]     d);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ SIG_W'(d);
  endfunction

  assign cnt_inc   = cnt_q + 1'b1;
  assign step      = (state_q == ST_RUN) && (hold_q == HOLD_LAST);
  assign last_step = step && cnt_inc[N];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort overrides everything, start only from IDLE/DONE.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            launch  = 1'b1;
          end
        end
        ST_RUN: begin
          if (last_step) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Hold and vector counters; both restart on launch and abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (bus.abort || launch) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (step) begin
      hold_q <= '0;
      cnt_q  <= cnt_inc;
    end else if (state_q == ST_RUN) begin
      hold_q <= hold_q + HW'(1);
    end
  end

  // Registered golden compare, captured on the final absorb edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
    end else if (bus.abort || launch) begin
      pass_q <= 1'b0;
    end else if (last_step) begin
      pass_q <= (misr_next(sig, bus.resp) == GOLDEN);
    end
  end

  assign misr_clr = launch || bus.abort;
  assign misr_en  = step && !bus.abort;

  bist_misr #(
    .SIG_W (SIG_W),
    .M     (M),
    .POLY  (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (bus.resp),
    .sig   (sig)
  );

  // Once the counter reaches 2^N the visible vector stays at all-ones.
  assign bus.vec       = cnt_q[N] ? {N{1'b1}} : cnt_q[N-1:0];
  assign bus.vec_valid = (state_q == ST_RUN);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = (state_q == ST_DONE) && pass_q;
  assign bus.signature = sig;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_bist_sweep.sv
// Bench for bist_sweep: table-driven sweeps on a default instance plus
// hand-written sequences for hold timing, abort, async reset and wider widths.
`timescale 1ns/1ps
module tb_bist_sweep;
  import bist_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- DUT instances ----------------
  bist_sweep_if #(.N(4), .M(2), .SIG_W(16)) if_a ();
  bist_sweep_if #(.N(4), .M(2), .SIG_W(16)) if_b ();
  bist_sweep_if #(.N(6), .M(3), .SIG_W(8))  if_c ();
  bist_sweep_if #(.N(4), .M(1), .SIG_W(16)) if_d ();

  bist_sweep #(.N(4), .M(2), .HOLD(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bist_sweep #(.N(4), .M(2), .HOLD(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  bist_sweep #(.N(6), .M(3), .HOLD(1), .SIG_W(8), .POLY(8'h1D))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));
  bist_sweep #(.N(4), .M(1), .HOLD(1), .GOLDEN(16'hFFFF))
    dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));

  // ---------------- DUT-under-test models ----------------
  logic [1:0] tbl_a [16];

  function automatic logic [1:0] gate4(input logic [3:0] v);
    return {~(v[0] | v[3]) ^ v[1], (v[0] & v[1]) | (v[2] ^ v[3])};
  endfunction

  function automatic logic [2:0] gate6(input logic [5:0] v);
    return {^v, v[5] & v[0], v[2] | v[4]};
  endfunction

  assign if_a.resp = tbl_a[if_a.vec];
  assign if_b.resp = gate4(if_b.vec);
  assign if_c.resp = gate6(if_c.vec);
  assign if_d.resp = 1'b1;

  // ---------------- reference model ----------------
  // One MISR step by arithmetic: doubling modulo 2^w, polynomial folded in
  // when the old value had its top bit set, response xored in.
  function automatic longint misr_ref(input int w, input longint poly,
                                      input longint cur, input longint r);
    longint modv;
    longint nxt;
    modv = longint'(1) << w;
    nxt  = (cur * 2) % modv;
    if (cur >= (modv / 2)) nxt = nxt ^ poly;
    return nxt ^ r;
  endfunction

  function automatic longint model_a(input logic [31:0] pat);
    longint s = 0;
    for (int i = 0; i < 16; i++) s = misr_ref(16, 64'h1021, s, longint'(pat[2*i +: 2]));
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_a(input logic [31:0] pat);
    for (int i = 0; i < 16; i++) tbl_a[i] = pat[2*i +: 2];
  endtask

  // Returns #1 after the edge that samples start.
  task automatic start_a();
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
  endtask

  task automatic wait_done_a(output int cyc);
    cyc = 0;
    while (!if_a.done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  typedef struct {
    logic [31:0] pat;
    logic [15:0] exp_sig;
    bit          exp_pass;
  } row_t;

  row_t rows[8];

  initial begin
    int cyc;
    logic [31:0] pat;
    longint sb;
    longint sc;

    rst_n = 1'b0;
    if_a.start = 0; if_a.abort = 0;
    if_b.start = 0; if_b.abort = 0;
    if_c.start = 0; if_c.abort = 0;
    if_d.start = 0; if_d.abort = 0;
    load_a(32'h0);

    // Stimulus table: constant responses with hand-derived signatures, then
    // random response tables whose expected values come from the model.
    rows[0] = '{32'h0000_0000, 16'h0000, 1'b1};
    rows[1] = '{32'h5555_5555, 16'hFFFF, 1'b0};
    rows[2] = '{32'hAAAA_AAAA, 16'hEFDF, 1'b0};
    for (int k = 3; k < 8; k++) begin
      rows[k].pat      = $urandom;
      rows[k].exp_sig  = 16'(model_a(rows[k].pat));
      rows[k].exp_pass = (rows[k].exp_sig == 16'h0);
    end

    // Reset state.
    #22;
    check("rst_vec",   if_a.vec, 0);
    check("rst_valid", if_a.vec_valid, 0);
    check("rst_busy",  if_a.busy, 0);
    check("rst_done",  if_a.done, 0);
    check("rst_pass",  if_a.pass, 0);
    check("rst_sig",   if_a.signature, 0);
    check("rst_state", if_a.state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sweeps; every row after the first restarts from DONE.
    for (int k = 0; k < 8; k++) begin
      load_a(rows[k].pat);
      exp_q.push_back(rows[k].exp_sig);
      start_a();
      check("start_busy",  if_a.busy, 1);
      check("start_valid", if_a.vec_valid, 1);
      check("start_vec",   if_a.vec, 0);
      check("start_sig",   if_a.signature, 0);
      check("start_done",  if_a.done, 0);
      check("start_pass",  if_a.pass, 0);
      wait_done_a(cyc);
      check("sweep_len",  cyc, 16);
      check("sweep_sig",  if_a.signature, exp_q.pop_front());
      check("sweep_pass", if_a.pass, rows[k].exp_pass);
      check("done_busy",  if_a.busy, 0);
      check("done_valid", if_a.vec_valid, 0);
      check("done_vec",   if_a.vec, 4'hF);
    end

    // start during RUN is ignored: duration and signature unchanged.
    pat = $urandom;
    load_a(pat);
    start_a();
    cyc = 0;
    while (!if_a.done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 5) if_a.start = 1'b1;
      if (cyc == 6) if_a.start = 1'b0;
    end
    check("ign_start_len", cyc, 16);
    check("ign_start_sig", if_a.signature, model_a(pat));

    // Abort at vector 7, then abort beating a simultaneous start.
    start_a();
    cyc = 0;
    while (if_a.vec != 4'd7 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reach7", cyc, 7);
    if_a.abort = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy",  if_a.busy, 0);
    check("abort_done",  if_a.done, 0);
    check("abort_valid", if_a.vec_valid, 0);
    check("abort_state", if_a.state, ST_IDLE);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_prio_state", if_a.state, ST_IDLE);
    check("abort_prio_busy",  if_a.busy, 0);
    if_a.abort = 1'b0;
    if_a.start = 1'b0;

    // Asynchronous reset between edges at vector 5.
    pat = $urandom;
    load_a(pat);
    start_a();
    cyc = 0;
    while (if_a.vec != 4'd5 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("arst_reach5", cyc, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vec",   if_a.vec, 0);
    check("arst_busy",  if_a.busy, 0);
    check("arst_valid", if_a.vec_valid, 0);
    check("arst_done",  if_a.done, 0);
    check("arst_pass",  if_a.pass, 0);
    check("arst_sig",   if_a.signature, 0);
    check("arst_state", if_a.state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    start_a();
    wait_done_a(cyc);
    check("arst_len", cyc, 16);
    check("arst_sig_after", if_a.signature, model_a(pat));

    // Constant 1-bit response with GOLDEN=FFFF.
    @(negedge clk);
    if_d.start = 1'b1;
    @(posedge clk);
    #1;
    if_d.start = 1'b0;
    cyc = 0;
    while (!if_d.done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("d_len",  cyc, 16);
    check("d_sig",  if_d.signature, 16'hFFFF);
    check("d_pass", if_d.pass, 1);

    // HOLD=3 with a gate model: every cycle checks the visited vector.
    sb = 0;
    for (int i = 0; i < 16; i++) sb = misr_ref(16, 64'h1021, sb, longint'(gate4(4'(i))));
    @(negedge clk);
    if_b.start = 1'b1;
    @(posedge clk);
    #1;
    if_b.start = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      check("b_vec",   if_b.vec, c / 3);
      check("b_valid", if_b.vec_valid, 1);
    end
    @(posedge clk);
    #1;
    check("b_done_48", if_b.done, 1);
    check("b_busy",    if_b.busy, 0);
    check("b_sig",     if_b.signature, sb);
    check("b_pass",    if_b.pass, (sb == 0));

    // N=6, M=3, SIG_W=8, POLY=1D.
    sc = 0;
    for (int i = 0; i < 64; i++) sc = misr_ref(8, 64'h1D, sc, longint'(gate6(6'(i))));
    @(negedge clk);
    if_c.start = 1'b1;
    @(posedge clk);
    #1;
    if_c.start = 1'b0;
    cyc = 0;
    while (!if_c.done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("c_len",  cyc, 64);
    check("c_sig",  if_c.signature, sc);
    check("c_vec",  if_c.vec, 6'h3F);
    check("c_pass", if_c.pass, (sc == 0));
    repeat (3) @(posedge clk);
    #1;
    check("c_vec_frozen",  if_c.vec, 6'h3F);
    check("c_done_held",   if_c.done, 1);
    check("c_sig_held",    if_c.signature, sc);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bist_sweep.md
# bist_sweep

Parametrised, synthesizable exhaustive-stimulus engine for combinational lab circuits. It drives all 2^N input combinations in ascending order into a device under test and holds each for a configurable number of cycles. The DUT responses are compacted into a multiple-input signature register (MISR), and the final signature is compared against a golden value. The block replaces hand-written per-vector benches and sits between the board clock/reset and any N-input, M-output combinational block.

## Interface
Parameters:
- N, 4: DUT input width; sweep length 2^N vectors.
- M, 2: DUT response width; M ≤ SIG_W.
- HOLD, 1: cycles each vector is held; ≥ 1.
- SIG_W, 16: MISR width.
- POLY, 16'h1021: MISR feedback polynomial (SIG_W bits).
- GOLDEN, 0: expected final signature.

Ports:
- clk, input, 1: the single clock; all state updates on the rising edge.
- rst_n, input, 1: reset; asynchronous, active-low.
- start, input, 1: begin a sweep; honoured only in IDLE or DONE.
- abort, input, 1: synchronous return to IDLE from any state.
- resp, input, M: DUT response to the current vec.
- vec, output, N: stimulus to the DUT.
- vec_valid, output, 1: high while vec is being applied (RUN).
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE; held until start, abort or reset.
- pass, output, 1: high in DONE when signature == GOLDEN.
- signature, output, SIG_W: current MISR contents.

## Operation
- Reset (rst_n low, any time, including mid-sweep): state IDLE; vec=0, vec_valid=0, busy=0, done=0, pass=0, signature=0, hold counter=0.
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on start.
  - RUN→DONE after the capture of vector 2^N−1.
  - DONE→RUN on start.
  - Any state→IDLE on abort. abort has priority over start.
- Entering RUN: signature cleared to 0, vec=0, hold counter=0.
- During RUN: the hold counter runs 0..HOLD−1. On the edge ending hold cycle HOLD−1, the MISR absorbs resp, vec increments, and the hold counter returns to 0.
- MISR update: sig' = (sig<<1) ^ (sig[SIG_W−1] ? POLY : 0) ^ zero-extend(resp).
- The vector counter is N+1 bits wide internally so 2^N−1→2^N is detected without wrap-around. vec shows the low N bits and is frozen at 2^N−1 in DONE.
- start during RUN is ignored.
- pass is a registered compare, valid whenever done=1 and forced 0 otherwise.

## Timing
- start sampled at edge t: from t, busy=1, vec_valid=1, vec=0.
- Vector i is applied from edge t+i·HOLD to edge t+(i+1)·HOLD. resp is sampled at the closing edge; the DUT is combinational, so no extra pipeline latency applies.
- done=1 and pass valid from edge t+2^N·HOLD. busy and vec_valid fall at the same edge.
- Sweep duration is exactly 2^N·HOLD cycles. For defaults: 16 cycles.
- Restart from DONE: the start edge clears done/pass and resets signature in the same edge.

## Structure
- Shared package/header bist_pkg holds:
  - FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default POLY constants for SIG_W 8/16/32.
- One sub-module, bist_misr(SIG_W, M, POLY). Its ports are clk, rst_n, clr, en, din[M], sig[SIG_W].
- The top level holds the FSM, hold counter, vector counter and compare.

## Test plan
- Zero response: resp tied 0, defaults, start pulse → done after 16 cycles, signature=16'h0000, pass=1.
- Constant response: M=1, resp tied 1, defaults → signature=16'hFFFF after 16 vectors; pass=0 (GOLDEN=0), and pass=1 when GOLDEN=16'hFFFF.
- Hold and order check with a 4-input/2-output gate model as the DUT, HOLD=3:
  - vec visits 0..15 ascending, each for exactly 3 cycles;
  - done rises 48 cycles after start;
  - signature equals the bench-side MISR model.
- Abort and ignored start: abort asserted at vector 7 → next edge IDLE, busy=0, done=0. start pulsed mid-RUN is ignored (total duration unchanged).
- Asynchronous reset mid-sweep: rst_n low between edges at vector 5 → outputs zero immediately with no clock edge. After release, start runs a full clean sweep with an identical signature.
- Width generalisation: N=6, M=3, SIG_W=8, POLY=8'h1D → 64 vectors, done at cycle 64, signature matches the model, vec frozen at 6'h3F in DONE.
